// File: rtl/pio_in_debounce_edge_pkg.sv
// pio_in_pkg: register map and reset constants for the debounced edge-capture PIO input.
package pio_in_pkg;
   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_RAW    = 3'd1;
   localparam logic [2:0] ADDR_MASK   = 3'd2;
   localparam logic [2:0] ADDR_EDGE   = 3'd3;
   localparam logic [2:0] ADDR_RISE   = 3'd4;
   localparam logic [2:0] ADDR_FALL   = 3'd5;
   localparam logic [2:0] ADDR_PERIOD = 3'd6;
   localparam logic [31:0] RISE_EN_RST = '1;
   localparam logic [31:0] FALL_EN_RST = '0;
endpackage

// File: rtl/pio_in_debounce_edge_if.sv
// pio_in_debounce_edge_if: Avalon-MM slave bus plus interrupt line of the PIO input.
interface pio_in_debounce_edge_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;
   modport master (output address, chipselect, write_n, writedata, input readdata, irq);
   modport slave (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/pio_in_debounce_edge_bit.sv
// pio_debounce_bit: one input bit -- synchroniser, debounce counter and edge detect.
module pio_debounce_bit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   input  logic [CNT_W-1:0] period,
   input  logic             rise_en,
   input  logic             fall_en,
   output logic             raw,
   output logic             stable,
   output logic             rise,
   output logic             fall
);
   logic s1, s2, stable_d;
   logic [CNT_W-1:0] cnt;
   assign raw = s2;
   assign rise = stable & ~stable_d & rise_en;
   assign fall = ~stable & stable_d & fall_en;
   // >= lets a shortened period take effect on a counter already past it
   always_ff @(posedge clk)
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         stable <= 1'b0;
         stable_d <= 1'b0;
         cnt <= '0;
      end else begin
         s1 <= din;
         s2 <= s1;
         stable_d <= stable;
         if (s2 == stable) cnt <= '0;
         else if (cnt >= period) begin
            stable <= s2;
            cnt <= '0;
         end else cnt <= cnt + 1'b1;
      end
endmodule

// File: rtl/pio_in_debounce_edge.sv
// pio_in_debounce_edge: Avalon-MM PIO input with debounce, edge capture and masked irq.
module pio_in_debounce_edge
   import pio_in_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 16,
   parameter int DEBOUNCE_DEFAULT = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_port,
   pio_in_debounce_edge_if.slave bus
);
   logic [WIDTH-1:0] raw, data, rise, fall, irq_mask, edge_cap, rise_en, fall_en, clr;
   logic [CNT_W-1:0] period;
   logic [31:0] rd;
   logic wr;
   logic unused_ok;
   assign wr = bus.chipselect & ~bus.write_n;
   assign clr = (wr && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;
   assign unused_ok = &{1'b0, bus.writedata};
   assign bus.irq = |(edge_cap & irq_mask);
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_debounce_bit #(.CNT_W(CNT_W)) u_bit (
         .clk(clk),
         .reset(reset),
         .din(in_port[i]),
         .period(period),
         .rise_en(rise_en[i]),
         .fall_en(fall_en[i]),
         .raw(raw[i]),
         .stable(data[i]),
         .rise(rise[i]),
         .fall(fall[i])
      );
   end
   always_comb begin
      rd = '0;
      case (bus.address)
         ADDR_DATA:   rd = 32'(data);
         ADDR_RAW:    rd = 32'(raw);
         ADDR_MASK:   rd = 32'(irq_mask);
         ADDR_EDGE:   rd = 32'(edge_cap);
         ADDR_RISE:   rd = 32'(rise_en);
         ADDR_FALL:   rd = 32'(fall_en);
         ADDR_PERIOD: rd = 32'(period);
         default:     rd = '0;
      endcase
   end
   // a new event in the same cycle as its clear keeps the capture bit set
   always_ff @(posedge clk)
      if (reset) begin
         irq_mask <= '0;
         edge_cap <= '0;
         rise_en <= WIDTH'(RISE_EN_RST);
         fall_en <= WIDTH'(FALL_EN_RST);
         period <= CNT_W'(DEBOUNCE_DEFAULT);
         bus.readdata <= '0;
      end else begin
         if (wr && bus.address == ADDR_MASK) irq_mask <= bus.writedata[WIDTH-1:0];
         if (wr && bus.address == ADDR_RISE) rise_en <= bus.writedata[WIDTH-1:0];
         if (wr && bus.address == ADDR_FALL) fall_en <= bus.writedata[WIDTH-1:0];
         if (wr && bus.address == ADDR_PERIOD) period <= bus.writedata[CNT_W-1:0];
         edge_cap <= (edge_cap & ~clr) | rise | fall;
         bus.readdata <= rd;
      end
endmodule

// File: tb/tb_pio_in_debounce_edge.sv
// tb_pio_in_debounce_edge: directed stimulus with a queued scoreboard checked by a separate monitor.
module tb_pio_in_debounce_edge;
   import pio_in_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [3:0] in_port = '0;
   pio_in_debounce_edge_if bus();
   pio_in_debounce_edge #(.WIDTH(4), .CNT_W(16), .DEBOUNCE_DEFAULT(50000)) dut (
      .clk(clk),
      .reset(reset),
      .in_port(in_port),
      .bus(bus)
   );
   typedef struct {
      bit          is_irq;
      logic [31:0] exp;
      string       name;
   } item_t;
   item_t q[$];
   int asrt = 0;
   int fails = 0;
   logic rd_req = 1'b0, irq_req = 1'b0, rd_tag = 1'b0, irq_tag = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) begin
      rd_tag <= rd_req;
      irq_tag <= irq_req;
   end
   always @(negedge clk) begin
      item_t it;
      logic [31:0] act;
      if (rd_tag || irq_tag) begin
         asrt++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard: observation with no expected entry");
         end else begin
            it = q.pop_front();
            act = it.is_irq ? {31'b0, bus.irq} : bus.readdata;
            if (act !== it.exp) begin
               fails++;
               $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
            end
         end
      end
   end
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      bus.address = a;
      bus.chipselect = 1'b1;
      bus.write_n = 1'b0;
      bus.writedata = d;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n = 1'b1;
   endtask
   task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
      item_t it;
      it.is_irq = 1'b0;
      it.exp = e;
      it.name = n;
      bus.address = a;
      q.push_back(it);
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
   endtask
   task automatic chk_irq(input logic e, input string n);
      item_t it;
      it.is_irq = 1'b1;
      it.exp = {31'b0, e};
      it.name = n;
      q.push_back(it);
      irq_req = 1'b1;
      @(negedge clk);
      irq_req = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.address = '0;
      bus.chipselect = 1'b0;
      bus.write_n = 1'b1;
      bus.writedata = '0;
      cyc(3);
      reset = 1'b0;
      rd(ADDR_PERIOD, 32'd50000, "rst_period");
      rd(ADDR_RISE, 32'hf, "rst_rise_en");
      rd(ADDR_FALL, 32'h0, "rst_fall_en");
      rd(ADDR_MASK, 32'h0, "rst_mask");
      rd(ADDR_EDGE, 32'h0, "rst_edge");
      rd(ADDR_DATA, 32'h0, "rst_data");
      rd(3'd7, 32'h0, "addr7");
      chk_irq(1'b0, "rst_irq");
      // basic rising edge, PERIOD=3
      wr(ADDR_PERIOD, 32'd3);
      in_port = 4'b0001;
      rd(ADDR_RAW, 32'h0, "raw_e0");
      rd(ADDR_RAW, 32'h0, "raw_e1");
      rd(ADDR_RAW, 32'h1, "raw_e2");
      rd(ADDR_DATA, 32'h0, "data_e3");
      rd(ADDR_DATA, 32'h0, "data_e4");
      rd(ADDR_DATA, 32'h0, "data_e5");
      rd(ADDR_EDGE, 32'h0, "edge_e6");
      rd(ADDR_EDGE, 32'h1, "edge_e7");
      rd(ADDR_DATA, 32'h1, "data_e8");
      chk_irq(1'b0, "irq_masked");
      wr(ADDR_MASK, 32'h1);
      chk_irq(1'b1, "irq_unmasked");
      rd(ADDR_MASK, 32'h1, "mask_rb");
      wr(ADDR_EDGE, 32'hf);
      rd(ADDR_EDGE, 32'h0, "edge_clear_all");
      chk_irq(1'b0, "irq_after_clear");
      wr(ADDR_MASK, 32'h0);
      // 3-cycle glitch rejected
      in_port = 4'b0101;
      rd(ADDR_RAW, 32'h1, "glitch_raw_e0");
      rd(ADDR_RAW, 32'h1, "glitch_raw_e1");
      rd(ADDR_RAW, 32'h5, "glitch_raw_e2");
      in_port = 4'b0001;
      rd(ADDR_RAW, 32'h5, "glitch_raw_e3");
      rd(ADDR_RAW, 32'h5, "glitch_raw_e4");
      rd(ADDR_RAW, 32'h1, "glitch_raw_e5");
      cyc(4);
      rd(ADDR_DATA, 32'h1, "glitch_data");
      rd(ADDR_EDGE, 32'h0, "glitch_edge");
      // 4-cycle pulse accepted
      in_port = 4'b0101;
      cyc(4);
      in_port = 4'b0001;
      rd(ADDR_DATA, 32'h1, "pulse4_data_e4");
      rd(ADDR_DATA, 32'h1, "pulse4_data_e5");
      rd(ADDR_DATA, 32'h5, "pulse4_data_e6");
      cyc(5);
      rd(ADDR_EDGE, 32'h4, "pulse4_edge");
      rd(ADDR_DATA, 32'h1, "pulse4_data_back");
      wr(ADDR_EDGE, 32'hf);
      // falling-only capture on bit 3
      wr(ADDR_RISE, 32'h0);
      wr(ADDR_FALL, 32'h8);
      in_port = 4'b1001;
      cyc(8);
      rd(ADDR_EDGE, 32'h0, "fall_only_rise");
      rd(ADDR_DATA, 32'h9, "fall_only_data_hi");
      in_port = 4'b0001;
      cyc(8);
      rd(ADDR_EDGE, 32'h8, "fall_only_fall");
      wr(ADDR_EDGE, 32'hf);
      rd(ADDR_EDGE, 32'h0, "fall_only_clear");
      // partial clear and clear/event collision
      wr(ADDR_RISE, 32'h2);
      wr(ADDR_FALL, 32'h1);
      in_port = 4'b0010;
      cyc(10);
      rd(ADDR_EDGE, 32'h3, "edge_two_bits");
      wr(ADDR_EDGE, 32'h1);
      rd(ADDR_EDGE, 32'h2, "edge_partial_clear");
      wr(ADDR_RISE, 32'h3);
      wr(ADDR_PERIOD, 32'd0);
      in_port = 4'b0011;
      cyc(3);
      wr(ADDR_EDGE, 32'h1);
      rd(ADDR_EDGE, 32'h3, "edge_clear_collision");
      // PERIOD=0 passes straight through
      in_port = 4'b0010;
      rd(ADDR_DATA, 32'h3, "p0_data_e0");
      rd(ADDR_DATA, 32'h3, "p0_data_e1");
      rd(ADDR_DATA, 32'h3, "p0_data_e2");
      rd(ADDR_DATA, 32'h2, "p0_data_e3");
      // period shortened mid-count
      wr(ADDR_PERIOD, 32'd100);
      in_port = 4'b0011;
      cyc(52);
      wr(ADDR_PERIOD, 32'd2);
      rd(ADDR_DATA, 32'h2, "shrink_data_before");
      rd(ADDR_DATA, 32'h3, "shrink_data_after");
      // reset mid-debounce
      wr(ADDR_MASK, 32'hf);
      chk_irq(1'b1, "irq_before_reset");
      in_port = 4'b1111;
      wr(ADDR_PERIOD, 32'd20);
      cyc(6);
      reset = 1'b1;
      rd(ADDR_EDGE, 32'h0, "reset_readdata");
      chk_irq(1'b0, "reset_irq");
      reset = 1'b0;
      rd(ADDR_MASK, 32'h0, "post_rst_mask");
      rd(ADDR_EDGE, 32'h0, "post_rst_edge");
      rd(ADDR_RISE, 32'hf, "post_rst_rise_en");
      rd(ADDR_FALL, 32'h0, "post_rst_fall_en");
      rd(ADDR_PERIOD, 32'd50000, "post_rst_period");
      rd(ADDR_DATA, 32'h0, "post_rst_data");
      chk_irq(1'b0, "post_rst_irq");
      wr(ADDR_DATA, 32'hf);
      rd(ADDR_DATA, 32'h0, "ro_write_ignored");
      wr(3'd7, 32'hffff_ffff);
      rd(3'd7, 32'h0, "addr7_write_ignored");
      cyc(3);
      if (q.size() != 0) begin
         asrt++;
         fails++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", asrt, fails);
      $finish;
   end
endmodule

// File: doc/pio_in_debounce_edge.md
# pio_in_debounce_edge

Parametrised successor to the switch/button PIO input. Exposes a WIDTH-bit `in_port` to the Nios II as an Avalon-MM slave with a two-flop synchroniser, per-bit programmable debounce, per-bit rising/falling edge selection, write-1-to-clear edge capture and a masked level interrupt. It sits between board switches/keys and the system interconnect, alongside the other PIO slaves in the video system.

## Interface
- `WIDTH`, 4, number of input bits (1..32)
- `CNT_W`, 16, debounce counter width (1..32)
- `DEBOUNCE_DEFAULT`, 50000 (truncated to CNT_W), reset value of the period register
- `clk` in 1: single clock; all logic on its rising edge
- `reset` in 1: synchronous, active-high; all state takes reset values on the edge where it is sampled high
- `address` in 3: register select
- `chipselect` in 1: slave select
- `write_n` in 1: active-low write strobe
- `writedata` in 32: write data; bits above the used width ignored
- `in_port` in WIDTH: asynchronous external inputs
- `readdata` out 32: registered read data, zero-extended
- `irq` out 1: interrupt, level, active-high

## Operation
- Register map (write = `chipselect & ~write_n`): 0 DATA (debounced, RO); 1 RAW (synchronised, RO); 2 IRQ_MASK (RW); 3 EDGE_CAPTURE (read; write-1-to-clear per bit); 4 RISE_EN (RW); 5 FALL_EN (RW); 6 PERIOD (RW, CNT_W bits); 7 reads 0, writes ignored. Writes to RO addresses ignored.
- Reset values: readdata 0, irq 0, sync flops 0, debounced 0, counters 0, IRQ_MASK 0, EDGE_CAPTURE 0, RISE_EN all ones, FALL_EN 0, PERIOD DEBOUNCE_DEFAULT.
- Synchroniser: `in_port` -> s1 -> s2; RAW = s2.
- Debounce, per bit, every cycle: if s2 == stable, cnt <= 0; else if cnt >= PERIOD, stable <= s2, cnt <= 0; else cnt <= cnt + 1. A change needs PERIOD+1 consecutive differing cycles of s2; glitches shorter than that are rejected. PERIOD = 0 means no filtering (stable follows s2 one cycle later). `>=` makes a PERIOD reduction mid-count take effect immediately; no counter overflow possible.
- Edge detect, per bit: stable_d <= stable; rise = stable & ~stable_d & RISE_EN; fall = ~stable & stable_d & FALL_EN. Any set event sets EDGE_CAPTURE bit.
- EDGE_CAPTURE write: bits with writedata 1 cleared, bits with 0 untouched. Simultaneous clear and new event on same bit: event wins (bit stays 1).
- irq = |(EDGE_CAPTURE & IRQ_MASK), combinational from registers.
- Input high at reset release is debounced normally and produces a rising event (after PERIOD+3 cycles) if RISE_EN set; software clears it at init.

## Timing
- Read latency 1: readdata updates every cycle from the address sampled on the previous edge (chipselect not required for reads; no side effects on read).
- Register writes visible on the next edge; IRQ_MASK change affects irq in the same cycle the register updates.
- in_port change (held, set up before edge 0) -> RAW updated after edge 1 -> DATA after edge PERIOD+2 -> EDGE_CAPTURE and irq after edge PERIOD+3.
- Reset mid-count: counters, stable, captures cleared; no event generated by reset itself.

## Structure
- Package `pio_in_pkg`: address constants ADDR_DATA..ADDR_PERIOD (3-bit localparams), RISE_EN/FALL_EN reset constants.
- Sub-module `pio_debounce_bit` (s1/s2, counter, stable, stable_d; outputs raw, stable, rise, fall), generated WIDTH times sharing PERIOD. Top holds registers, capture, irq, read mux.

## Test plan
- Reset, PERIOD=3, in_port 0000->0001 held -> DATA reads 1 after edge 5, EDGE_CAPTURE=0001 after edge 6; irq 0 with IRQ_MASK 0, 1 after writing IRQ_MASK=0001.
- PERIOD=3, pulse bit 2 high for 3 cycles -> RAW shows pulse, DATA stays 0, EDGE_CAPTURE 0; 4-cycle pulse -> DATA bit 2 rises.
- RISE_EN=0, FALL_EN=1000, bit 3 0->1->0 -> only the falling transition sets EDGE_CAPTURE=1000.
- EDGE_CAPTURE=0011, write 0001 to addr 3 -> reads 0010; write 0001 in the same cycle a new bit-0 event occurs -> bit 0 stays 1.
- PERIOD=0 -> DATA follows in_port after 2 edges; write PERIOD 100->2 while cnt=50 -> stable updates next cycle.
- Assert reset mid-debounce with input high -> all registers at reset values on next edge, irq 0, readdata 0.
